// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and imem write-port bundle for imem_boot_loader.
// master: byte source side (drives the stream, observes the imem port).
// slave : the loader (accepts the stream, drives the imem write port).
interface imem_boot_loader_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_last;
    logic              in_ready;
    logic [ADDR_W-1:0] imem_address;
    logic [31:0]       imem_data;
    logic              imem_wren;

    modport master (
        output in_valid, in_byte, in_last,
        input  in_ready, imem_address, imem_data, imem_wren
    );

    modport slave (
        input  in_valid, in_byte, in_last,
        output in_ready, imem_address, imem_data, imem_wren
    );
endinterface

// File: rtl/imem_boot_loader.sv
// imem_boot_loader: assembles a big-endian byte stream into 32-bit words,
// writes them to imem while holding the processor in reset, then releases it.
// Optional feature macro: IMEM_BOOT_CHECKSUM_EN adds a 32-bit running sum
// of every word presented for writing (dropped overflow words included).
module imem_boot_loader #(
    parameter int ADDR_W     = 12,
    parameter int RESET_HOLD = 2
) (
    input  logic                clock,
    input  logic                reset,
    imem_boot_loader_if.slave   bus,
    output logic                proc_reset,
    output logic                done,
    output logic [ADDR_W:0]     words_loaded,
    output logic                err_overflow
`ifdef IMEM_BOOT_CHECKSUM_EN
    ,
    output logic [31:0]         checksum
`endif
);

    // Hold counter only needs to reach RESET_HOLD-1.
    localparam int HOLD_W = (RESET_HOLD > 1) ? $clog2(RESET_HOLD) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
    // Pointer value meaning "imem full"; the pointer saturates here.
    localparam logic [ADDR_W:0] FULL = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [1:0] {
        ACCEPT,
        WRITE,
        HOLD,
        RUN
    } state_t;

    state_t            state;
    logic [1:0]        byte_idx;
    logic [23:0]       asm_q;      // previously accepted bytes of the current word
    logic              word_last;  // current word carried in_last
    logic [HOLD_W-1:0] hold_cnt;
    logic              hs;
    logic              imem_full;
    logic [31:0]       shifted;
    logic [31:0]       word_next;

    assign hs        = bus.in_valid & bus.in_ready;
    assign imem_full = (words_loaded == FULL);

    // Word as it would look with the incoming byte appended; a short final
    // word is left-justified so its unfilled low bytes read as zero.
    always_comb begin
        shifted   = {asm_q, bus.in_byte};
        word_next = shifted << {3'd3 - {1'b0, byte_idx}, 3'b000};
    end

    // Loader state machine; every output is a register updated here.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= ACCEPT;
            byte_idx         <= '0;
            asm_q            <= '0;
            word_last        <= 1'b0;
            hold_cnt         <= '0;
            bus.in_ready     <= 1'b0;
            bus.imem_address <= '0;
            bus.imem_data    <= '0;
            bus.imem_wren    <= 1'b0;
            proc_reset       <= 1'b1;
            done             <= 1'b0;
            words_loaded     <= '0;
            err_overflow     <= 1'b0;
`ifdef IMEM_BOOT_CHECKSUM_EN
            checksum         <= '0;
`endif
        end else begin
            case (state)
                ACCEPT: begin
                    bus.in_ready <= 1'b1;
                    if (hs) begin
                        asm_q    <= {asm_q[15:0], bus.in_byte};
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3 || bus.in_last) begin
                            state            <= WRITE;
                            bus.in_ready     <= 1'b0;
                            bus.imem_address <= words_loaded[ADDR_W-1:0];
                            bus.imem_data    <= word_next;
                            bus.imem_wren    <= !imem_full;
                            word_last        <= bus.in_last;
                        end
                    end
                end

                WRITE: begin
                    bus.imem_wren <= 1'b0;
                    byte_idx      <= '0;
                    if (imem_full)
                        err_overflow <= 1'b1;
                    else
                        words_loaded <= words_loaded + 1'b1;
`ifdef IMEM_BOOT_CHECKSUM_EN
                    checksum <= checksum + bus.imem_data;
`endif
                    if (word_last) begin
                        state    <= HOLD;
                        hold_cnt <= '0;
                    end else begin
                        state        <= ACCEPT;
                        bus.in_ready <= 1'b1;
                    end
                end

                HOLD: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state      <= RUN;
                        proc_reset <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end

                RUN: begin
                    // Terminal until reset.
                    state <= RUN;
                end

                default: state <= ACCEPT;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader. The reference model
// packs the program bytes into big-endian words with plain arithmetic and
// predicts the imem writes, counters, flags and release timing.
module tb_imem_boot_loader;

    localparam int AW    = 3;
    localparam int RH    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          proc_reset;
    logic          done;
    logic          err_overflow;
    logic [AW:0]   words_loaded;
`ifdef IMEM_BOOT_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    imem_boot_loader_if #(.ADDR_W(AW)) ifc ();

    imem_boot_loader #(.ADDR_W(AW), .RESET_HOLD(RH)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (ifc),
        .proc_reset   (proc_reset),
        .done         (done),
        .words_loaded (words_loaded),
        .err_overflow (err_overflow)
`ifdef IMEM_BOOT_CHECKSUM_EN
        ,
        .checksum     (checksum)
`endif
    );

    always #5 clock = ~clock;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  prog_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    int          cyc = 0;
    int          last_wr_cyc = -1;
    int          rel_cyc = -1;
    int          rdy_in_write = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Observe the imem port and release away from the rising edge.
    initial begin
        forever begin
            @(negedge clock);
            cyc++;
            if (ifc.imem_wren === 1'b1) begin
                wr_addr_q.push_back(ifc.imem_address);
                wr_data_q.push_back(ifc.imem_data);
                last_wr_cyc = cyc;
                if (ifc.in_ready !== 1'b0) rdy_in_write++;
            end
            if (proc_reset === 1'b0 && rel_cyc < 0) rel_cyc = cyc;
        end
    end

    task automatic apply_reset();
        @(negedge clock);
        #2;
        reset = 1'b0;
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        ifc.in_byte  = 8'h00;
        #1;
        wr_addr_q.delete();
        wr_data_q.delete();
        rel_cyc = -1;
        last_wr_cyc = -1;
        rdy_in_write = 0;
        check("rst_in_ready",   64'(ifc.in_ready), 64'd0);
        check("rst_wren",       64'(ifc.imem_wren), 64'd0);
        check("rst_address",    64'(ifc.imem_address), 64'd0);
        check("rst_data",       64'(ifc.imem_data), 64'd0);
        check("rst_proc_reset", 64'(proc_reset), 64'd1);
        check("rst_done",       64'(done), 64'd0);
        check("rst_words",      64'(words_loaded), 64'd0);
        check("rst_overflow",   64'(err_overflow), 64'd0);
`ifdef IMEM_BOOT_CHECKSUM_EN
        check("rst_checksum",   64'(checksum), 64'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("rdy_before_edge", 64'(ifc.in_ready), 64'd0);
        @(negedge clock);
        check("rdy_first_edge", 64'(ifc.in_ready), 64'd1);
    endtask

    // mode 0: no stalls, 1: valid every other cycle, 2: random stalls.
    task automatic drive_prog(input int mode, input int nmax);
        int   i = 0;
        int   guard = 0;
        int   ph = 0;
        logic v;
        logic hs;
        while (i < nmax && guard < 400) begin
            @(negedge clock);
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (ph % 2 == 0);
            else                v = ($urandom_range(0, 3) != 0);
            ph++;
            ifc.in_valid = v;
            if (v) begin
                ifc.in_byte = prog_q[i];
                ifc.in_last = (i == prog_q.size() - 1);
            end else begin
                ifc.in_byte = 8'($urandom);
                ifc.in_last = 1'($urandom);
            end
            hs = v && ifc.in_ready;
            @(posedge clock);
            if (hs) i++;
            guard++;
        end
        @(negedge clock);
        ifc.in_valid = 1'b0;
        ifc.in_last  = 1'b0;
        if (i < nmax) check("drive_timeout", 64'(i), 64'(nmax));
    endtask

    task automatic wait_done();
        int g = 0;
        while (done !== 1'b1 && g < 100) begin
            @(negedge clock);
            g++;
        end
        check("done_timeout", 64'(done), 64'd1);
    endtask

    task automatic check_result();
        int          n = prog_q.size();
        int          nw = (n + 3) / 4;
        int          nexp;
        logic [31:0] words[$];
        logic [31:0] sum = 32'd0;
        for (int k = 0; k < nw; k++) begin
            logic [31:0] w = 32'd0;
            for (int b = 0; b < 4; b++)
                if (4 * k + b < n) w = w | (32'(prog_q[4 * k + b]) << (24 - 8 * b));
            words.push_back(w);
            sum = sum + w;
        end
        nexp = (nw < DEPTH) ? nw : DEPTH;
        check("write_count", 64'(wr_data_q.size()), 64'(nexp));
        for (int k = 0; k < nexp && k < wr_data_q.size(); k++) begin
            check("write_addr", 64'(wr_addr_q[k]), 64'(k));
            check("write_data", 64'(wr_data_q[k]), 64'(words[k]));
        end
        check("words_loaded", 64'(words_loaded), 64'(nexp));
        check("err_overflow", 64'(err_overflow), 64'(nw > DEPTH));
        check("proc_reset_low", 64'(proc_reset), 64'd0);
        check("in_ready_in_run", 64'(ifc.in_ready), 64'd0);
        check("in_ready_in_write", 64'(rdy_in_write), 64'd0);
        if (nw <= DEPTH) check("release_gap", 64'(rel_cyc - last_wr_cyc), 64'(1 + RH));
`ifdef IMEM_BOOT_CHECKSUM_EN
        check("checksum", 64'(checksum), 64'(sum));
`endif
    endtask

    task automatic run_prog(input int mode);
        apply_reset();
        drive_prog(mode, prog_q.size());
        wait_done();
        check_result();
    endtask

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_byte  = 8'h00;
        ifc.in_last  = 1'b0;

        // Single full word, no stalls.
        prog_q = '{8'h20, 8'h01, 8'h00, 8'h05};
        run_prog(0);

        // Short final word gets zero-padded low bytes.
        prog_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        run_prog(0);

        // Valid on alternate cycles.
        prog_q.delete();
        for (int k = 0; k < 8; k++) prog_q.push_back(8'($urandom));
        run_prog(1);

        // Wrap-around checksum words.
        prog_q = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02};
        run_prog(0);

        // Random programs up to exactly full imem.
        for (int t = 0; t < 6; t++) begin
            int n = (t == 5) ? 4 * DEPTH : $urandom_range(1, 4 * DEPTH);
            prog_q.delete();
            for (int k = 0; k < n; k++) prog_q.push_back(8'($urandom));
            run_prog($urandom_range(0, 2));
        end

        // Overflow: two extra words, the last one partial.
        prog_q.delete();
        for (int k = 0; k < 4 * (DEPTH + 1) + 2; k++) prog_q.push_back(8'($urandom));
        run_prog(2);

        // Asynchronous reset after release re-asserts proc_reset at once.
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_proc_reset", 64'(proc_reset), 64'd1);
        check("async_done", 64'(done), 64'd0);

        // Reset after two bytes of word 1.
        prog_q.delete();
        for (int k = 0; k < 12; k++) prog_q.push_back(8'($urandom));
        apply_reset();
        drive_prog(0, 6);
        check("mid_words", 64'(words_loaded), 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_proc_reset", 64'(proc_reset), 64'd1);
        check("mid_in_ready", 64'(ifc.in_ready), 64'd0);
        check("mid_words_clr", 64'(words_loaded), 64'd0);
        check("mid_wren", 64'(ifc.imem_wren), 64'd0);

        // Reload restarts at address 0.
        prog_q.delete();
        for (int k = 0; k < 8; k++) prog_q.push_back(8'($urandom));
        run_prog(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
